imm_pixel_feeder: RTL

Upstream stage of the image masking core (imm). Scans a frame stored in synchronous-read image RAM in raster order and fetches one pixel per read. Presents each 12-bit pixel with its row/col coordinates on a valid/ready stream, which connects directly to imm's image_pixel/pixel_row/pixel_col inputs. Absorbs downstream backpressure without dropping or duplicating pixels.

---
 rtl/imm_pkg.sv | 27 ++
 rtl/imm_pixel_feeder_if.sv | 36 +++
 rtl/imm_skid_buf.sv | 59 +++++
 rtl/imm_pixel_feeder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared types and widths for the image masking core (imm) pixel paths.
//   PIX_W/ROW_W/COL_W : pixel, row and column widths
//   state_t           : scan controller states
//   beat_t            : one pixel beat {pix, row, col} as carried on the stream
// -----------------------------------------------------------------------------
package imm_pkg;

    localparam int unsigned PIX_W = 12;
    localparam int unsigned ROW_W = 8;
    localparam int unsigned COL_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } beat_t;

endpackage

// File: rtl/imm_pixel_feeder_if.sv
// -----------------------------------------------------------------------------
// imm_pixel_feeder_if
// Pixel stream between the feeder and imm.
//   image_pixel : pixel value
//   pixel_row   : row of image_pixel
//   pixel_col   : col of image_pixel
//   pixel_valid : beat valid (source -> sink)
//   pixel_ready : sink accepts beat (sink -> source)
// Modports: master = stream source, slave = stream sink.
// -----------------------------------------------------------------------------
interface imm_pixel_feeder_if;
    import imm_pkg::*;

    logic [PIX_W-1:0] image_pixel;
    logic [ROW_W-1:0] pixel_row;
    logic [COL_W-1:0] pixel_col;
    logic             pixel_valid;
    logic             pixel_ready;

    modport master (
        output image_pixel,
        output pixel_row,
        output pixel_col,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  image_pixel,
        input  pixel_row,
        input  pixel_col,
        input  pixel_valid,
        output pixel_ready
    );

endinterface

// File: rtl/imm_skid_buf.sv
// -----------------------------------------------------------------------------
// imm_skid_buf
// Output register plus one-entry skid register carrying beat_t.
//   clk, rst_n  : clock, synchronous active-low reset
//   in_valid    : input beat valid (no input ready: the producer meters its
//                 issue rate so that at most one beat ever needs the skid)
//   in_beat     : input beat
//   out_valid   : output beat valid
//   out_beat    : output beat, held stable while out_valid & !out_ready
//   out_ready   : sink accepts output beat
//   skid_valid  : skid entry occupied (producers use it for space accounting)
// The skid is always drained into the output before new input is taken.
// -----------------------------------------------------------------------------
module imm_skid_buf
    import imm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  out_valid,
    output beat_t out_beat,
    input  logic  out_ready,
    output logic  skid_valid
);

    beat_t skid_beat;
    logic  out_free;

    // Output can take a new beat when empty or transferring this cycle.
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_beat   <= '0;
            skid_valid <= 1'b0;
            skid_beat  <= '0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_beat   <= skid_beat;
                skid_valid <= in_valid;
                if (in_valid) begin
                    skid_beat <= in_beat;
                end
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_beat <= in_beat;
                end
            end
        end else if (in_valid) begin
            skid_valid <= 1'b1;
            skid_beat  <= in_beat;
        end
    end

endmodule

// File: rtl/imm_pixel_feeder.sv
// -----------------------------------------------------------------------------
// imm_pixel_feeder
// Scans a frame held in synchronous-read image RAM in raster order (col
// fastest) and streams each pixel with its row/col to imm.
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : pulse, starts a frame scan when idle
//   mem_rd_en   : RAM read strobe
//   mem_addr    : RAM read address (row*IMG_WIDTH+col)
//   mem_data    : RAM read data, valid the cycle after mem_rd_en
//   pix_if      : pixel stream source (image_pixel/pixel_row/pixel_col,
//                 pixel_valid/pixel_ready)
//   busy        : frame in progress (RUN, DRAIN, DONE)
//   frame_done  : one-cycle pulse after the last pixel transfers
// Optional build macro IMM_FEED_ROI_EN adds roi_row0/roi_row1/roi_col0/
// roi_col1 (sampled at start); only the rectangle they bound is scanned.
// -----------------------------------------------------------------------------
module imm_pixel_feeder
    import imm_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned ADDR_W     = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef IMM_FEED_ROI_EN
    input  logic [ROW_W-1:0]      roi_row0,
    input  logic [ROW_W-1:0]      roi_row1,
    input  logic [COL_W-1:0]      roi_col0,
    input  logic [COL_W-1:0]      roi_col1,
`endif
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [PIX_W-1:0]      mem_data,
    imm_pixel_feeder_if.master    pix_if,
    output logic                  busy,
    output logic                  frame_done
);

    state_t            state, state_nx;
    logic [ROW_W-1:0]  frow;
    logic [COL_W-1:0]  fcol;
    logic [ADDR_W-1:0] addr;

    logic              rd_pending;
    logic [ROW_W-1:0]  pend_row;
    logic [COL_W-1:0]  pend_col;

    logic              out_valid;
    logic              skid_valid;
    beat_t             in_beat;
    beat_t             out_beat;

    logic [1:0]        occ;
    logic              xfer;
    logic              space;
    logic              rd_issue;
    logic              last_read;
    logic              last_xfer;
    logic              scan_go;
    logic              scan_empty;

    // Scan rectangle: col_lo/col_hi/row_hi bound the fetch counters,
    // row_step is the address jump taken at each row wrap.
    logic [ROW_W-1:0]  row_hi;
    logic [COL_W-1:0]  col_lo;
    logic [COL_W-1:0]  col_hi;
    logic [ADDR_W-1:0] row_step;

`ifdef IMM_FEED_ROI_EN
    logic [ROW_W-1:0]  roi_row1_q;
    logic [COL_W-1:0]  roi_col0_q;
    logic [COL_W-1:0]  roi_col1_q;
    logic [ADDR_W-1:0] row_step_q;

    assign row_hi     = roi_row1_q;
    assign col_lo     = roi_col0_q;
    assign col_hi     = roi_col1_q;
    assign row_step   = row_step_q;
    assign scan_empty = (roi_row0 > roi_row1) || (roi_col0 > roi_col1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            roi_row1_q <= '0;
            roi_col0_q <= '0;
            roi_col1_q <= '0;
            row_step_q <= '0;
        end else if (scan_go) begin
            roi_row1_q <= roi_row1;
            roi_col0_q <= roi_col0;
            roi_col1_q <= roi_col1;
            row_step_q <= ADDR_W'(IMG_WIDTH - 32'(roi_col1 - roi_col0));
        end
    end
`else
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

    assign row_hi     = LAST_ROW;
    assign col_lo     = '0;
    assign col_hi     = LAST_COL;
    assign row_step   = ADDR_W'(1);
    assign scan_empty = 1'b0;
`endif

    // Space accounting: beats in the output, the skid and the RAM pipeline.
    assign occ       = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pending};
    assign xfer      = out_valid && pix_if.pixel_ready;
    assign space     = (occ < 2'd2) || ((occ == 2'd2) && xfer);
    assign rd_issue  = (state == RUN) && space;
    assign last_read = (frow == row_hi) && (fcol == col_hi);
    // Once all reads are issued, the final beat is the sole occupant.
    assign last_xfer = xfer && !skid_valid && !rd_pending;

    assign mem_rd_en  = rd_issue;
    assign mem_addr   = (state == RUN) ? addr : '0;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        scan_go  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    scan_go  = 1'b1;
                    state_nx = scan_empty ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_issue && last_read) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Fetch counters advance only when a read issues; the coordinates of
    // each read ride along in pend_row/pend_col to meet the returning data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frow       <= '0;
            fcol       <= '0;
            addr       <= '0;
            rd_pending <= 1'b0;
            pend_row   <= '0;
            pend_col   <= '0;
        end else begin
            rd_pending <= rd_issue;
            if (rd_issue) begin
                pend_row <= frow;
                pend_col <= fcol;
            end
            if (scan_go) begin
`ifdef IMM_FEED_ROI_EN
                frow <= roi_row0;
                fcol <= roi_col0;
                addr <= ADDR_W'(32'(roi_row0) * IMG_WIDTH + 32'(roi_col0));
`else
                frow <= '0;
                fcol <= '0;
                addr <= '0;
`endif
            end else if (rd_issue) begin
                if (fcol == col_hi) begin
                    fcol <= col_lo;
                    frow <= frow + ROW_W'(1);
                    addr <= addr + row_step;
                end else begin
                    fcol <= fcol + COL_W'(1);
                    addr <= addr + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        in_beat     = '0;
        in_beat.pix = mem_data;
        in_beat.row = pend_row;
        in_beat.col = pend_col;
    end

    imm_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (rd_pending),
        .in_beat    (in_beat),
        .out_valid  (out_valid),
        .out_beat   (out_beat),
        .out_ready  (pix_if.pixel_ready),
        .skid_valid (skid_valid)
    );

    assign pix_if.pixel_valid = out_valid;
    assign pix_if.image_pixel = out_beat.pix;
    assign pix_if.pixel_row   = out_beat.row;
    assign pix_if.pixel_col   = out_beat.col;

endmodule
